// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract sequencer. It drives one shared external 8-bit adder, one byte per cycle, LSB first.
// Optional macro ADD_SATURATE_EN: when defined, a signed overflow saturates the result instead of wrapping it.
module byte_serial_add_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic                  iSub,
    input  logic [8*NBYTES-1:0]   iOp_a,
    input  logic [8*NBYTES-1:0]   iOp_b,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [8*NBYTES-1:0]   oResult,
    output logic                  oCarry,
    output logic                  oOverflow,
    output logic [7:0]            oAdd_a,
    output logic [7:0]            oAdd_b,
    output logic                  oAdd_c,
    input  logic [7:0]            iAdd_s,
    input  logic                  iAdd_c
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IW   = $clog2(NBYTES);
    localparam int unsigned LAST = NBYTES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   index;
    logic            carryReg;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic [W-9:0]    resAcc;

    logic [W-1:0]    sumFull;
    logic            ovfNow;
    logic [W-1:0]    finalRes;

    // The final byte comes straight from the adder, so flags and the result are formed from it in the same cycle.
    always_comb begin
        sumFull = {iAdd_s, resAcc};
        ovfNow  = (opA[W-1] == opB[W-1]) && (iAdd_s[7] != opA[W-1]);
`ifdef ADD_SATURATE_EN
        if (ovfNow) begin
            finalRes = opA[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            finalRes = sumFull;
        end
`else
        finalRes = sumFull;
`endif
    end

    // The adder inputs depend only on registers, so they stay stable for the whole cycle.
    always_comb begin
        oAdd_a = 8'h00;
        oAdd_b = 8'h00;
        oAdd_c = 1'b0;
        if (state == RUN) begin
            oAdd_a = opA[{index, 3'b000} +: 8];
            oAdd_b = opB[{index, 3'b000} +: 8];
            oAdd_c = carryReg;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            index     <= '0;
            carryReg  <= 1'b0;
            opA       <= '0;
            opB       <= '0;
            resAcc    <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oResult   <= '0;
            oCarry    <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                RUN: begin
                    carryReg <= iAdd_c;
                    if (index == IW'(LAST)) begin
                        state     <= DONE;
                        index     <= '0;
                        oBusy     <= 1'b0;
                        oDone     <= 1'b1;
                        oResult   <= finalRes;
                        oCarry    <= iAdd_c;
                        oOverflow <= ovfNow;
                    end else begin
                        resAcc[{index, 3'b000} +: 8] <= iAdd_s;
                        index <= index + IW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request. For subtraction, B is stored inverted and the carry-in is set.
                    if (iStart) begin
                        state    <= RUN;
                        opA      <= iOp_a;
                        opB      <= iSub ? ~iOp_b : iOp_b;
                        carryReg <= iSub;
                        index    <= '0;
                        oBusy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench for byte_serial_add_ctrl. The bench models the shared adder and predicts results with wide arithmetic.
module tb_byte_serial_add_ctrl;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStart;
    logic          iSub;
    logic [W-1:0]  iOp_a;
    logic [W-1:0]  iOp_b;
    logic          oBusy;
    logic          oDone;
    logic [W-1:0]  oResult;
    logic          oCarry;
    logic          oOverflow;
    logic [7:0]    oAdd_a;
    logic [7:0]    oAdd_b;
    logic          oAdd_c;
    logic [7:0]    iAdd_s;
    logic          iAdd_c;

    int            nCmp  = 0;
    int            nFail = 0;
    int            opNum = 0;
    logic [W-1:0]  lastRes = '0;

    byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iSub(iSub),
        .iOp_a(iOp_a), .iOp_b(iOp_b), .oBusy(oBusy), .oDone(oDone),
        .oResult(oResult), .oCarry(oCarry), .oOverflow(oOverflow),
        .oAdd_a(oAdd_a), .oAdd_b(oAdd_b), .oAdd_c(oAdd_c),
        .iAdd_s(iAdd_s), .iAdd_c(iAdd_c)
    );

    always #5 iClk = ~iClk;

    // Shared 8-bit ripple adder, purely combinational.
    assign {iAdd_c, iAdd_s} = 9'(oAdd_a) + 9'(oAdd_b) + 9'(oAdd_c);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] res, output logic cy, output logic ovf);
        longint sa;
        longint sb;
        longint r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = sub ? sa - sb : sa + sb;
        ovf = (r != longint'($signed(W'(r))));
        cy  = sub ? (a >= b) : 1'((64'(a) + 64'(b)) >> W);
        res = W'(r);
`ifdef ADD_SATURATE_EN
        if (ovf) res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    endtask

    task automatic checkZeroOuts(input string tag);
        check($sformatf("%s busy", tag), 64'(oBusy), 64'(0));
        check($sformatf("%s done", tag), 64'(oDone), 64'(0));
        check($sformatf("%s result", tag), 64'(oResult), 64'(0));
        check($sformatf("%s carry", tag), 64'(oCarry), 64'(0));
        check($sformatf("%s ovf", tag), 64'(oOverflow), 64'(0));
        check($sformatf("%s adder", tag), {39'(0), oAdd_a, oAdd_b, oAdd_c}, 64'(0));
    endtask

    // Called on a negedge. The task returns on the negedge of the DONE cycle.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic midPulse);
        logic [W-1:0] beff;
        logic [W-1:0] res;
        logic         cy;
        logic         ovf;
        logic [63:0]  mask;
        opNum++;
        model(a, b, sub, res, cy, ovf);
        beff   = sub ? ~b : b;
        iOp_a  = a;
        iOp_b  = b;
        iSub   = sub;
        iStart = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iStart = 1'b0;
        iOp_a  = $urandom;
        iOp_b  = $urandom;
        iSub   = 1'($urandom);
        for (int k = 0; k < int'(NBYTES); k++) begin
            mask = (64'(1) << (8 * k)) - 64'(1);
            check($sformatf("op%0d b%0d busy", opNum, k), 64'(oBusy), 64'(1));
            check($sformatf("op%0d b%0d done", opNum, k), 64'(oDone), 64'(0));
            check($sformatf("op%0d b%0d addA", opNum, k), 64'(oAdd_a), 64'(a[8*k +: 8]));
            check($sformatf("op%0d b%0d addB", opNum, k), 64'(oAdd_b), 64'(beff[8*k +: 8]));
            check($sformatf("op%0d b%0d addC", opNum, k), 64'(oAdd_c),
                  64'(1'(((64'(a) & mask) + (64'(beff) & mask) + 64'(sub)) >> (8 * k))));
            iStart = midPulse && (k == 1);
            @(posedge iClk);
            @(negedge iClk);
        end
        iStart = 1'b0;
        check($sformatf("op%0d done", opNum), 64'(oDone), 64'(1));
        check($sformatf("op%0d busyOff", opNum), 64'(oBusy), 64'(0));
        check($sformatf("op%0d result", opNum), 64'(oResult), 64'(res));
        check($sformatf("op%0d carry", opNum), 64'(oCarry), 64'(cy));
        check($sformatf("op%0d ovf", opNum), 64'(oOverflow), 64'(ovf));
        check($sformatf("op%0d adderIdle", opNum), {39'(0), oAdd_a, oAdd_b, oAdd_c}, 64'(0));
        lastRes = res;
    endtask

    task automatic idleCycle();
        @(posedge iClk);
        @(negedge iClk);
        check($sformatf("op%0d idle done", opNum), 64'(oDone), 64'(0));
        check($sformatf("op%0d idle busy", opNum), 64'(oBusy), 64'(0));
        check($sformatf("op%0d held", opNum), 64'(oResult), 64'(lastRes));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        iRst = 1'b1; iStart = 1'b0; iSub = 1'b0; iOp_a = '0; iOp_b = '0;
        @(negedge iClk);
        checkZeroOuts("reset");
        iRst = 1'b0;
        @(negedge iClk);

        runOp(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); idleCycle();
        runOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); idleCycle();
        runOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); idleCycle();
        runOp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0); idleCycle();
        // Mid-run pulse on iStart must be ignored, then a second op starts straight from DONE.
        runOp(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        runOp(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0); idleCycle();

        // Asynchronous reset while index 2 is on the adder.
        iOp_a = 32'hAABB_CCDD; iOp_b = 32'h1122_3344; iSub = 1'b0; iStart = 1'b1;
        @(posedge iClk); @(negedge iClk);
        iStart = 1'b0;
        @(posedge iClk); @(negedge iClk);
        @(posedge iClk); @(negedge iClk);
        check("rst idx2 addA", 64'(oAdd_a), 64'(8'hBB));
        iRst = 1'b1;
        #1;
        checkZeroOuts("midRst");
        @(posedge iClk); @(negedge iClk);
        iRst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge iClk); @(negedge iClk);
            check($sformatf("postRst c%0d done", i), 64'(oDone), 64'(0));
        end
        lastRes = '0;
        idleCycle();
        runOp(32'hAABB_CCDD, 32'h1122_3344, 1'b0, 1'b0); idleCycle();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = {1'b0, {(W-1){1'b1}}};
            if (i % 6 == 3) ra = {1'b1, {(W-1){1'b0}}};
            runOp(ra, rb, 1'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) idleCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
